line_buf_ctrl: RTL and testbench
================================

LINE_BUF_CTRL -- requirements
Module: line_buf_ctrl

Interface
REQ-001 SHALL have parameter IMAGE_W, default 16, pixels per image row.
REQ-002 SHALL have parameter IMAGE_H, default 16, rows per frame.
REQ-003 SHALL have parameter KERNEL_SIZE, default 3, window height in rows.
REQ-004 SHALL have parameter NUM_BANKS, default 4, row buffers in the rotating set; NUM_BANKS >= KERNEL_SIZE and IMAGE_H >= KERNEL_SIZE, else elaboration error.
REQ-005 SHALL have parameter ADDR_W, default 4, column address width; 2**ADDR_W >= IMAGE_W.
REQ-006 SHALL have ports clk (in, 1, clock) and rst (in, 1, reset); reset rst, asynchronous, active-low; clock clk.
REQ-007 SHALL have port frame_start (in, 1): one-cycle pulse that begins a frame.
REQ-008 SHALL have port in_valid (in, 1): pixel present this cycle.
REQ-009 SHALL have port in_ready (out, 1): pixel accepted when in_valid && in_ready.
REQ-010 SHALL have port row_done (in, 1): consumer has finished the current window.
REQ-011 SHALL have port wr_en (out, NUM_BANKS): one-hot bank write strobe.
REQ-012 SHALL have port wr_addr (out, ADDR_W): column address for the write.
REQ-013 SHALL have port top_bank (out, clog2(NUM_BANKS)): bank holding the oldest row of the window.
REQ-014 SHALL have ports win_valid (out, 1), row_start (out, 1), out_row (out, clog2(IMAGE_H)), frame_done (out, 1) and busy (out, 1).

Function
REQ-015 SHALL implement FSM IDLE, FILL, STREAM, DRAIN.
REQ-016 IDLE -> FILL on frame_start; frame_start is ignored outside IDLE.
REQ-017 FILL -> STREAM when occupancy reaches KERNEL_SIZE.
REQ-018 STREAM -> DRAIN when IMAGE_H rows have been written.
REQ-019 DRAIN -> IDLE on the row_done of the final window, where out_row == IMAGE_H-KERNEL_SIZE.
REQ-020 in_ready = (state is FILL or STREAM) && (occupancy < NUM_BANKS) && (rows_written < IMAGE_H).
REQ-021 wr_en: bit wr_bank equals (in_valid && in_ready), combinationally; all other bits are 0.
REQ-022 wr_addr SHALL equal the registered col counter.
REQ-023 On an accepted pixel col increments; at IMAGE_W-1, col wraps to 0, wr_bank advances modulo NUM_BANKS, rows_written+1 and occupancy+1.
REQ-024 win_valid = (occupancy >= KERNEL_SIZE) && (state is STREAM or DRAIN).
REQ-025 row_done is honoured only when win_valid = 1; it then decrements occupancy, advances top_bank modulo NUM_BANKS and increments out_row.
REQ-026 If a row completes in the same cycle as an honoured row_done, occupancy SHALL remain unchanged and both counters advance.
REQ-027 row_start SHALL be a registered one-cycle pulse in the cycle after win_valid rises.
REQ-028 row_start SHALL also pulse in the cycle after an honoured, non-final row_done that leaves occupancy >= KERNEL_SIZE.
REQ-029 frame_done SHALL be a registered one-cycle pulse in the cycle after the final row_done.
REQ-030 On the final row_done, occupancy, col, wr_bank, top_bank, rows_written and out_row SHALL clear.
REQ-031 busy = (state != IDLE).
REQ-032 Occupancy SHALL never exceed NUM_BANKS and never underflow; in_ready masking guarantees that no unreleased row is overwritten.

Reset
REQ-033 While rst = 0, the block SHALL enter IDLE asynchronously, with all counters 0 and in_ready, wr_en, win_valid, row_start, frame_done and busy at 0.
REQ-034 Reset mid-frame SHALL abandon the frame; after release, the block SHALL wait for a new frame_start.

Verification (IMAGE_W=4, IMAGE_H=5, KERNEL_SIZE=3, NUM_BANKS=4)
REQ-035 Assert rst = 0 mid-stream -> all outputs 0 and state IDLE immediately; in_valid is ignored until frame_start.
REQ-036 frame_start, then 12 back-to-back pixels -> wr_en = 0001, 0010, 0100, each with wr_addr 0..3; win_valid rises after the 12th pixel; row_start pulses 1 cycle later; top_bank = 0.
REQ-037 No row_done, continue streaming -> row 3 is written to bank 3 (1000); occupancy = 4; in_ready = 0 thereafter, with no wr_en asserted.
REQ-038 row_done while in_ready = 0 -> top_bank = 1, out_row = 1, row_start pulses; row 4 is written to bank 0 (wrap).
REQ-039 row_done in the same cycle as the last pixel of a row -> occupancy unchanged; top_bank and wr_bank both advance.
REQ-040 Full frame -> exactly 3 row_start pulses; frame_done is a single pulse the cycle after the 3rd row_done; busy = 0; a second frame_start restarts writing at bank 0, address 0.

Source files
------------

// File: rtl/line_buf_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : line_buf_ctrl
// Description : Rotating row-buffer controller that fills KERNEL_SIZE rows,
//               then presents a sliding window of rows to a consumer.
// Revision    : 1.0 - initial release
// ============================================================================
module line_buf_ctrl #(
    parameter int IMAGE_W     = 16,
    parameter int IMAGE_H     = 16,
    parameter int KERNEL_SIZE = 3,
    parameter int NUM_BANKS   = 4,
    parameter int ADDR_W      = 4,
    localparam int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int ROW_W      = (IMAGE_H > 1) ? $clog2(IMAGE_H) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 row_done,
    output logic [NUM_BANKS-1:0] wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [BANK_W-1:0]    top_bank,
    output logic                 win_valid,
    output logic                 row_start,
    output logic [ROW_W-1:0]     out_row,
    output logic                 frame_done,
    output logic                 busy
);

    localparam int OCC_W = $clog2(NUM_BANKS + 1);
    localparam int RW_W  = $clog2(IMAGE_H + 1);

    localparam logic [ADDR_W-1:0] c_last_col     = ADDR_W'(IMAGE_W - 1);
    localparam logic [BANK_W-1:0] c_last_bank    = BANK_W'(NUM_BANKS - 1);
    localparam logic [ROW_W-1:0]  c_last_out_row = ROW_W'(IMAGE_H - KERNEL_SIZE);
    localparam logic [OCC_W-1:0]  c_kernel       = OCC_W'(KERNEL_SIZE);
    localparam logic [OCC_W-1:0]  c_max_occ      = OCC_W'(NUM_BANKS);
    localparam logic [RW_W-1:0]   c_rows         = RW_W'(IMAGE_H);

    if (NUM_BANKS < KERNEL_SIZE || IMAGE_H < KERNEL_SIZE || (2 ** ADDR_W) < IMAGE_W)
    begin : g_param_check
        $error("line_buf_ctrl: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic [BANK_W-1:0] wr_bank_q, wr_bank_d;
    logic [BANK_W-1:0] top_bank_q, top_bank_d;
    logic [RW_W-1:0]   rows_written_q, rows_written_d;
    logic [ROW_W-1:0]  out_row_q, out_row_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              win_valid_prev_q, win_valid_prev_d;
    logic              row_start_q, row_start_d;
    logic              frame_done_q, frame_done_d;

    logic w_accept;
    logic w_row_complete;
    logic w_row_release;
    logic w_final;

    assign busy      = (state_q != ST_IDLE);
    assign in_ready  = ((state_q == ST_FILL) || (state_q == ST_STREAM)) &&
                       (occ_q < c_max_occ) && (rows_written_q < c_rows);
    assign win_valid = (occ_q >= c_kernel) &&
                       ((state_q == ST_STREAM) || (state_q == ST_DRAIN));

    assign w_accept       = in_valid && in_ready;
    assign w_row_complete = w_accept && (col_q == c_last_col);
    assign w_row_release  = row_done && win_valid;
    assign w_final        = w_row_release && (out_row_q == c_last_out_row);

    assign wr_addr    = col_q;
    assign top_bank   = top_bank_q;
    assign out_row    = out_row_q;
    assign row_start  = row_start_q;
    assign frame_done = frame_done_q;

    always_comb begin
        wr_en = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            wr_en[b] = w_accept && (wr_bank_q == BANK_W'(b));
        end
    end

    always_comb begin
        state_d        = state_q;
        col_d          = col_q;
        wr_bank_d      = wr_bank_q;
        top_bank_d     = top_bank_q;
        rows_written_d = rows_written_q;
        out_row_d      = out_row_q;
        occ_d          = occ_q;

        if (w_accept) begin
            col_d = w_row_complete ? '0 : col_q + 1'b1;
        end
        if (w_row_complete) begin
            wr_bank_d      = (wr_bank_q == c_last_bank) ? '0 : wr_bank_q + 1'b1;
            rows_written_d = rows_written_q + 1'b1;
        end
        if (w_row_release) begin
            top_bank_d = (top_bank_q == c_last_bank) ? '0 : top_bank_q + 1'b1;
            out_row_d  = out_row_q + 1'b1;
        end

        // A row landing while another is released leaves occupancy as is.
        case ({w_row_complete, w_row_release})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (occ_d >= c_kernel) begin
                    state_d = (rows_written_d == c_rows) ? ST_DRAIN : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (rows_written_d == c_rows) begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                if (w_final) begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        if (w_final || (state_q == ST_IDLE)) begin
            col_d          = '0;
            wr_bank_d      = '0;
            top_bank_d     = '0;
            rows_written_d = '0;
            out_row_d      = '0;
            occ_d          = '0;
        end

        win_valid_prev_d = win_valid;
        // New window either from a rising win_valid or from a release that keeps one ready.
        row_start_d  = (win_valid && !win_valid_prev_q) ||
                       (w_row_release && !w_final && (occ_d >= c_kernel));
        frame_done_d = w_final;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= ST_IDLE;
            col_q            <= '0;
            wr_bank_q        <= '0;
            top_bank_q       <= '0;
            rows_written_q   <= '0;
            out_row_q        <= '0;
            occ_q            <= '0;
            win_valid_prev_q <= 1'b0;
            row_start_q      <= 1'b0;
            frame_done_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            col_q            <= col_d;
            wr_bank_q        <= wr_bank_d;
            top_bank_q       <= top_bank_d;
            rows_written_q   <= rows_written_d;
            out_row_q        <= out_row_d;
            occ_q            <= occ_d;
            win_valid_prev_q <= win_valid_prev_d;
            row_start_q      <= row_start_d;
            frame_done_q     <= frame_done_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_line_buf_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_buf_ctrl
// Description : Directed and random stimulus for line_buf_ctrl against a
//               pixel-count reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_buf_ctrl;

    localparam int W = 4;
    localparam int H = 5;
    localparam int K = 3;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_start;
    logic       in_valid;
    logic       in_ready;
    logic       row_done;
    logic [3:0] wr_en;
    logic [3:0] wr_addr;
    logic [1:0] top_bank;
    logic       win_valid;
    logic       row_start;
    logic [2:0] out_row;
    logic       frame_done;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int rs_seen  = 0;
    int fd_seen  = 0;

    // Reference model: everything is derived from pixels accepted and rows released.
    logic m_active   = 1'b0;
    int   m_pix      = 0;
    int   m_rel      = 0;
    logic m_prev_win = 1'b0;
    logic m_rs       = 1'b0;
    logic m_fd       = 1'b0;

    line_buf_ctrl #(
        .IMAGE_W(W), .IMAGE_H(H), .KERNEL_SIZE(K), .NUM_BANKS(N), .ADDR_W(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .row_done   (row_done),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .top_bank   (top_bank),
        .win_valid  (win_valid),
        .row_start  (row_start),
        .out_row    (out_row),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active   = 1'b0;
        m_pix      = 0;
        m_rel      = 0;
        m_prev_win = 1'b0;
        m_rs       = 1'b0;
        m_fd       = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".in_ready"},   32'(in_ready),   32'd0);
        chk({tag, ".wr_en"},      32'(wr_en),      32'd0);
        chk({tag, ".wr_addr"},    32'(wr_addr),    32'd0);
        chk({tag, ".top_bank"},   32'(top_bank),   32'd0);
        chk({tag, ".out_row"},    32'(out_row),    32'd0);
        chk({tag, ".win_valid"},  32'(win_valid),  32'd0);
        chk({tag, ".row_start"},  32'(row_start),  32'd0);
        chk({tag, ".frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, ".busy"},       32'(busy),       32'd0);
    endtask

    // One clock: drive inputs, compare every output with the model, then advance the model.
    task automatic step(input logic fs, input logic iv, input logic rd);
        int   rows, occ, rows_a, rel_a;
        logic e_ir, e_win, acc, hon, fin;
        logic [3:0] e_wen;
        @(negedge clk);
        frame_start = fs;
        in_valid    = iv;
        row_done    = rd;
        #1;
        rows  = m_pix / W;
        occ   = rows - m_rel;
        e_ir  = m_active && (occ < N) && (rows < H);
        e_win = m_active && (rows >= K) && (occ >= K);
        acc   = iv && e_ir;
        hon   = rd && e_win;
        fin   = hon && (m_rel == H - K);
        e_wen = acc ? (4'b0001 << (rows % N)) : 4'b0000;
        chk("in_ready",   32'(in_ready),   32'(e_ir));
        chk("wr_en",      32'(wr_en),      32'(e_wen));
        chk("wr_addr",    32'(wr_addr),    32'(m_pix % W));
        chk("top_bank",   32'(top_bank),   32'(m_rel % N));
        chk("out_row",    32'(out_row),    32'(m_rel));
        chk("win_valid",  32'(win_valid),  32'(e_win));
        chk("row_start",  32'(row_start),  32'(m_rs));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
        chk("busy",       32'(busy),       32'(m_active));
        if (row_start === 1'b1) rs_seen++;
        if (frame_done === 1'b1) fd_seen++;
        @(posedge clk);
        rows_a = (m_pix + (acc ? 1 : 0)) / W;
        rel_a  = m_rel + (hon ? 1 : 0);
        m_rs   = (e_win && !m_prev_win) || (hon && !fin && (rows_a - rel_a >= K));
        m_fd   = fin;
        m_prev_win = e_win;
        if (!m_active) begin
            if (fs) begin
                m_active = 1'b1;
                m_pix    = 0;
                m_rel    = 0;
            end
        end else if (fin) begin
            m_active = 1'b0;
            m_pix    = 0;
            m_rel    = 0;
        end else begin
            m_pix = m_pix + (acc ? 1 : 0);
            m_rel = rel_a;
        end
    endtask

    task automatic mid_reset(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero(tag);
        model_reset();
        @(negedge clk);
        #1;
        chk_all_zero({tag, "_held"});
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b0;
        frame_start = 1'b0;
        in_valid    = 1'b0;
        row_done    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // Pixels offered while idle are not accepted.
        repeat (3) step(1'b0, 1'b1, 1'b0);

        // Frame 1: fill three rows, overfill to four, then release and drain.
        rs_seen = 0;
        fd_seen = 0;
        step(1'b1, 1'b0, 1'b0);
        repeat (12) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("win_after_fill", 32'(win_valid), 32'd1);
        chk("top_after_fill", 32'(top_bank), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        repeat (6) step(1'b0, 1'b1, 1'b0);
        chk("ready_when_full", 32'(in_ready), 32'd0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("top_after_release", 32'(top_bank), 32'd1);
        repeat (4) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("row_start_count", 32'(rs_seen), 32'd3);
        chk("frame_done_count", 32'(fd_seen), 32'd1);
        chk("busy_after_frame", 32'(busy), 32'd0);

        // Frame 2: restart at bank 0, then release on the last pixel of a row.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        repeat (11) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b1, 1'b0);

        // Reset while streaming abandons the frame.
        mid_reset("mid_reset");
        repeat (3) step(1'b0, 1'b1, 1'b0);

        // Random traffic across many frames.
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) mid_reset("rand_reset");
            step(($urandom % 6) == 0, ($urandom % 4) != 0, ($urandom % 3) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
